// File: rtl/wptr_full_gen.sv
// Write-side pointer and full-flag generator for an asynchronous FIFO.
// Holds the binary/Gray write pointer, synchronises the read-domain Gray pointer
// into the write clock and derives full, almost-full, fill level and overflow.
module wptr_full_gen #(
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned AFULL_TH    = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              winc,
  input  logic [ADDR_W:0]   rptr_gray_async,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W:0]   wptr_gray,
  output logic              wfull,
  output logic              walmost_full,
  output logic [ADDR_W:0]   wlevel,
  output logic              wr_ovf
);

  localparam logic [ADDR_W:0] AfullTh = (ADDR_W + 1)'(AFULL_TH);

  // Architectural state
  logic [ADDR_W:0] wbin_q, wbin_d;
  logic [ADDR_W:0] wgray_q, wgray_d;
  logic [ADDR_W:0] sync_q [SYNC_STAGES];
  logic [ADDR_W:0] sync_d [SYNC_STAGES];
  logic            wfull_q, wfull_d;
  logic            wafull_q, wafull_d;
  logic [ADDR_W:0] wlevel_q, wlevel_d;
  logic            ovf_q, ovf_d;

  // Derived combinational values
  logic            wr_en;
  logic [ADDR_W:0] rq_gray;
  logic [ADDR_W:0] rbin_sync;
  logic [ADDR_W:0] full_gray;

  assign rq_gray = sync_q[SYNC_STAGES-1];

  // Synchroniser shift: the raw async pointer lands directly in the first flop
  always_comb begin
    for (int i = 0; i < int'(SYNC_STAGES); i++) begin
      sync_d[i] = '0;
    end
    sync_d[0] = rptr_gray_async;
    for (int i = 1; i < int'(SYNC_STAGES); i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // Gray-to-binary of the synchronised read pointer (XOR-prefix from the MSB)
  always_comb begin
    rbin_sync = '0;
    for (int i = 0; i <= int'(ADDR_W); i++) begin
      rbin_sync[i] = ^(rq_gray >> i);
    end
  end

  // Next write pointer and flag computation; flags look at the post-write pointer
  always_comb begin
    wr_en     = winc & ~wfull_q;
    wbin_d    = wbin_q + (ADDR_W + 1)'(wr_en);
    wgray_d   = wbin_d ^ (wbin_d >> 1);
    // Write pointer one full lap ahead of the read pointer: top two Gray bits inverted
    full_gray = {~rq_gray[ADDR_W:ADDR_W-1], rq_gray[ADDR_W-2:0]};
    wfull_d   = (wgray_d == full_gray);
    // Read pointer lags, so this level can only overestimate occupancy
    wlevel_d  = wbin_d - rbin_sync;
    wafull_d  = (wlevel_d >= AfullTh);
    ovf_d     = ovf_q | (winc & wfull_q);
  end

  // State update with synchronous, active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wbin_q   <= '0;
      wgray_q  <= '0;
      wfull_q  <= 1'b0;
      wafull_q <= 1'b0;
      wlevel_q <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      wbin_q   <= wbin_d;
      wgray_q  <= wgray_d;
      wfull_q  <= wfull_d;
      wafull_q <= wafull_d;
      wlevel_q <= wlevel_d;
      ovf_q    <= ovf_d;
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= sync_d[i];
      end
    end
  end

  assign waddr        = wbin_q[ADDR_W-1:0];
  assign wptr_gray    = wgray_q;
  assign wfull        = wfull_q;
  assign walmost_full = wafull_q;
  assign wlevel       = wlevel_q;
  assign wr_ovf       = ovf_q;

endmodule

// File: tb/tb_wptr_full_gen.sv
// Bench for wptr_full_gen: occupancy-level model checked every cycle plus
// directed scenarios with hand-computed literal expectations.
module tb_wptr_full_gen;

  localparam int AW   = 4;
  localparam int SYNC = 2;
  localparam int TH   = 12;
  localparam int MOD  = 1 << (AW + 1);
  localparam int DEP  = 1 << AW;

  logic          clk;
  logic          rst;
  logic          winc;
  logic [AW:0]   rptr_gray_async;
  logic [AW-1:0] waddr;
  logic [AW:0]   wptr_gray;
  logic          wfull;
  logic          walmost_full;
  logic [AW:0]   wlevel;
  logic          wr_ovf;

  wptr_full_gen #(
    .ADDR_W      (AW),
    .SYNC_STAGES (SYNC),
    .AFULL_TH    (TH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .winc            (winc),
    .rptr_gray_async (rptr_gray_async),
    .waddr           (waddr),
    .wptr_gray       (wptr_gray),
    .wfull           (wfull),
    .walmost_full    (walmost_full),
    .wlevel          (wlevel),
    .wr_ovf          (wr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Read side driven as a binary count; the Gray form goes to the DUT
  int rd_drv = 0;
  task automatic set_rd(input int b);
    logic [AW:0] v;
    rd_drv = b % MOD;
    v = rd_drv[AW:0];
    rptr_gray_async = v ^ (v >> 1);
  endtask

  // Model: count of accepted writes, read count as seen SYNC edges late
  int m_w = 0, m_lvl = 0;
  bit m_full = 0, m_afull = 0, m_ovf = 0;
  int hist [SYNC];

  function automatic int gray_of(input int b);
    return (b ^ (b >> 1)) % MOD;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_w = 0; m_lvl = 0; m_full = 0; m_afull = 0; m_ovf = 0;
      for (int i = 0; i < SYNC; i++) hist[i] = 0;
    end else begin
      int rs;
      bit acc;
      rs    = hist[SYNC-1];
      acc   = winc && !m_full;
      m_ovf = m_ovf || (winc && m_full);
      m_w   = (m_w + (acc ? 1 : 0)) % MOD;
      m_lvl = (m_w - rs + MOD) % MOD;
      m_full  = (m_lvl == DEP);
      m_afull = (m_lvl >= TH);
      for (int i = SYNC - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = rd_drv;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("waddr", int'(waddr), m_w % DEP);
      check("wptr_gray", int'(wptr_gray), gray_of(m_w));
      check("wfull", int'(wfull), int'(m_full));
      check("walmost_full", int'(walmost_full), int'(m_afull));
      check("wlevel", int'(wlevel), m_lvl);
      check("wr_ovf", int'(wr_ovf), int'(m_ovf));
    end
  end

  initial begin
    int n;
    int wcnt;
    logic [AW:0] prev;
    rst  = 1'b1;
    winc = 1'b0;
    set_rd(0);
    for (int i = 0; i < SYNC; i++) hist[i] = 0;

    // 1. reset for two edges
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_waddr", int'(waddr), 0);
    check("rst_wptr_gray", int'(wptr_gray), 0);
    check("rst_wfull", int'(wfull), 0);
    check("rst_wlevel", int'(wlevel), 0);
    check("rst_wr_ovf", int'(wr_ovf), 0);
    chk_en = 1'b1;
    rst = 1'b0;

    // 2. sixteen back-to-back writes, read pointer parked at 0
    for (int i = 1; i <= 16; i++) begin
      winc = 1'b1;
      @(negedge clk);
      check("afull_at_write", int'(walmost_full), (i >= 12) ? 1 : 0);
    end
    check("full_gray", int'(wptr_gray), 24);
    check("full_flag", int'(wfull), 1);
    check("full_level", int'(wlevel), 16);

    // 3. writes while full are dropped
    repeat (2) @(negedge clk);
    winc = 1'b0;
    @(negedge clk);
    check("ovf_gray_hold", int'(wptr_gray), 24);
    check("ovf_set", int'(wr_ovf), 1);
    @(negedge clk);
    check("ovf_sticky", int'(wr_ovf), 1);

    // 4. one read: full drops after the sync latency
    set_rd(1);
    n = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (!wfull) begin
        n = k;
        break;
      end
    end
    check("full_fall_edges", n, 3);
    check("level_after_read", int'(wlevel), 15);

    // 5. forty writes with reader trailing by four; wraps the pointer
    rst = 1'b1;
    set_rd(0);
    @(negedge clk);
    rst  = 1'b0;
    wcnt = 0;
    prev = wptr_gray;
    for (int i = 1; i <= 40; i++) begin
      winc = 1'b1;
      set_rd((wcnt >= 4) ? wcnt - 4 : 0);
      @(negedge clk);
      wcnt++;
      check("gray_hamming", $countones(prev ^ wptr_gray), 1);
      check("track_no_full", int'(wfull), 0);
      if (i == 32) begin
        check("wrap_gray", int'(wptr_gray), 0);
        check("wrap_waddr", int'(waddr), 0);
      end
      prev = wptr_gray;
    end

    // 6. reset after seven writes, with winc held high
    winc = 1'b0;
    rst  = 1'b1;
    set_rd(0);
    @(negedge clk);
    rst  = 1'b0;
    winc = 1'b1;
    repeat (7) @(negedge clk);
    check("pre_rst_waddr", int'(waddr), 7);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_waddr", int'(waddr), 0);
    check("mid_rst_gray", int'(wptr_gray), 0);
    check("mid_rst_wfull", int'(wfull), 0);
    check("mid_rst_afull", int'(walmost_full), 0);
    check("mid_rst_level", int'(wlevel), 0);
    check("mid_rst_ovf", int'(wr_ovf), 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_waddr", int'(waddr), 1);
    winc = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
